regfile_sb: RTL

Parametrised register file with a per-register pending-write scoreboard, for the decode stage of the 5-stage pipeline. It provides two combinational read ports with write-through bypass, one write port, and a hardwired zero register. Per-register pending counters track in-flight writes issued from decode and drive a hazard (stall) output toward the hazard unit.

---
 rtl/regfile_sb.sv | 110 +++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Decode-stage register file: two bypassed read ports, one write port, r0 hardwired
// to zero, and per-register pending-write counters that drive the decode stall.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              rs_use,
    input  logic              rt_use,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              hazard,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              iss_rdy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wb_orphan
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [PEND_W-1:0] pend_q [DEPTH];
    logic [PEND_W-1:0] pend_d [DEPTH];
    logic              orphan_q;
    logic              orphan_d;

    logic              wr_live;
    logic              iss_acc;
    logic              wb_dec;
    logic [PEND_W-1:0] rs_pend;
    logic [PEND_W-1:0] rt_pend;
    logic              rs_busy;
    logic              rt_busy;

    assign wr_live = wr_en && (wr_addr != '0);

    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs_addr != '0) begin
            rs_data = (wr_en && (wr_addr == rs_addr)) ? wr_data : regs_q[rs_addr];
        end
        if (rt_addr != '0) begin
            rt_data = (wr_en && (wr_addr == rt_addr)) ? wr_data : regs_q[rt_addr];
        end
    end

    // A last-outstanding writeback this cycle is not a hazard: the bypass covers it.
    always_comb begin
        rs_pend = pend_q[rs_addr];
        rt_pend = pend_q[rt_addr];
        rs_busy = (rs_addr != '0) && (rs_pend != '0) &&
                  !(wr_en && (wr_addr == rs_addr) && (rs_pend == PEND_W'(1)));
        rt_busy = (rt_addr != '0) && (rt_pend != '0) &&
                  !(wr_en && (wr_addr == rt_addr) && (rt_pend == PEND_W'(1)));
        hazard  = (rs_use && rs_busy) || (rt_use && rt_busy);
    end

    always_comb begin
        iss_rdy  = (iss_addr == '0) || (pend_q[iss_addr] != '1);
        iss_acc  = iss_en && iss_rdy && (iss_addr != '0);
        wb_dec   = wr_live && (pend_q[wr_addr] != '0);
        orphan_d = orphan_q ||
                   (wr_live && (pend_q[wr_addr] == '0) && !(iss_acc && (iss_addr == wr_addr)));
    end

    always_comb begin
        pend_d = pend_q;
        if (!(iss_acc && wb_dec && (iss_addr == wr_addr))) begin
            if (iss_acc) begin
                pend_d[iss_addr] = pend_q[iss_addr] + PEND_W'(1);
            end
            if (wb_dec) begin
                pend_d[wr_addr] = pend_q[wr_addr] - PEND_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pend_q[i] <= '0;
            end
            orphan_q <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            orphan_q <= orphan_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_live) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    assign wb_orphan = orphan_q;

endmodule
